wb_sram_bank_bridge: RTL

//  Wishbone classic slave exposing NUM_BANKS OpenRAM 1rw1r macros (port 0, the rw port) to the management SoC.

---
 rtl/wb_sram_pkg.sv | 32 +++
 rtl/wb_sram_rdmux.sv | 19 +
 rtl/wb_sram_bank_bridge.sv | 137 +++++++++++++
 3 files changed

// File: rtl/wb_sram_pkg.sv
// Shared state type, decode helpers and parameter limits for the Wishbone-to-SRAM bank bridge.
package wb_sram_pkg;

  localparam int unsigned NUM_BANKS_MIN = 1;
  localparam int unsigned NUM_BANKS_MAX = 8;
  localparam int unsigned ADDR_W_MIN    = 1;
  localparam int unsigned ADDR_W_MAX    = 16;
  localparam int unsigned RD_WAIT_MAX   = 7;
  localparam int unsigned WAIT_CNT_W    = $clog2(RD_WAIT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    ACK
  } state_t;

  // The bank field can encode NUM_BANKS itself, so the slot just past the last
  // bank decodes as an acked out-of-range access instead of aliasing bank 0.
  function automatic int unsigned bs_w(input int unsigned num_banks);
    int unsigned w;
    w = $clog2(num_banks + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Byte-address bits that lie inside the decoded window (word + bank fields).
  function automatic logic [31:0] win_mask(input int unsigned num_banks,
                                           input int unsigned addr_w);
    return (32'd1 << (addr_w + 2 + bs_w(num_banks))) - 32'd1;
  endfunction

endpackage

// File: rtl/wb_sram_rdmux.sv
// Read-data selector: picks the latched bank's 32-bit slice of the macro outputs.
module wb_sram_rdmux #(
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned BS_W      = 2
) (
  input  logic [32*NUM_BANKS-1:0] dout,
  input  logic [BS_W-1:0]         bank,
  output logic [31:0]             data
);

  // Bank indices with no macro behind them read as zero.
  always_comb begin
    data = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (bank == BS_W'(b)) data = dout[32*b +: 32];
    end
  end

endmodule

// File: rtl/wb_sram_bank_bridge.sv
// Wishbone classic slave driving port 0 of NUM_BANKS OpenRAM 1rw1r macros.
module wb_sram_bank_bridge
  import wb_sram_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned ADDR_W    = 9,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned RD_WAIT   = 0
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [NUM_BANKS-1:0]    sram_csb,
  output logic                    sram_web,
  output logic [3:0]              sram_wmask,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic [31:0]             sram_din,
  input  logic [32*NUM_BANKS-1:0] sram_dout,
  output logic                    busy_o
);

  localparam int unsigned BS_W = bs_w(NUM_BANKS);
  localparam logic [31:0] WIN_MASK = win_mask(NUM_BANKS, ADDR_W);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(RD_WAIT);

  state_t                  state;
  logic [BS_W-1:0]         bank_q;
  logic                    we_q;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic [31:0]             rd_data;

  logic                    hit;
  logic [ADDR_W-1:0]       adr_word;
  logic [BS_W-1:0]         adr_bank;
  logic [NUM_BANKS-1:0]    csb_next;

  assign hit      = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ~WIN_MASK) == BASE_ADDR);
  assign adr_word = wbs_adr_i[ADDR_W+1:2];
  assign adr_bank = wbs_adr_i[ADDR_W+BS_W+1:ADDR_W+2];

  // Only a real bank is selected, and an all-zero byte-select write never touches the macro.
  always_comb begin
    csb_next = '1;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (adr_bank == BS_W'(b) && !(wbs_we_i && wbs_sel_i == 4'h0)) csb_next[b] = 1'b0;
    end
  end

  wb_sram_rdmux #(
    .NUM_BANKS(NUM_BANKS),
    .BS_W     (BS_W)
  ) u_rdmux (
    .dout(sram_dout),
    .bank(bank_q),
    .data(rd_data)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      bank_q     <= '0;
      we_q       <= 1'b0;
      wait_cnt   <= '0;
      sram_csb   <= '1;
      sram_web   <= 1'b1;
      sram_wmask <= '0;
      sram_addr  <= '0;
      sram_din   <= '0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      busy_o     <= 1'b0;
    end else if (state != IDLE && !wbs_cyc_i) begin
      // Master abandoned the cycle; a write the macro already sampled stays written.
      state      <= IDLE;
      sram_csb   <= '1;
      sram_web   <= 1'b1;
      sram_wmask <= '0;
      wbs_ack_o  <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            state      <= ACCESS;
            busy_o     <= 1'b1;
            bank_q     <= adr_bank;
            we_q       <= wbs_we_i;
            sram_addr  <= adr_word;
            sram_din   <= wbs_dat_i;
            sram_web   <= ~wbs_we_i;
            sram_wmask <= wbs_we_i ? wbs_sel_i : 4'h0;
            sram_csb   <= csb_next;
          end
        end
        ACCESS: begin
          sram_csb   <= '1;
          sram_web   <= 1'b1;
          sram_wmask <= '0;
          if (we_q) begin
            state     <= ACK;
            wbs_ack_o <= 1'b1;
          end else begin
            state    <= WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state     <= ACK;
            wbs_dat_o <= rd_data;
            wbs_ack_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ACK: begin
          state     <= IDLE;
          wbs_ack_o <= 1'b0;
          busy_o    <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          wbs_ack_o <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule
